// File: rtl/wb_sram_responder_if.sv
// Wishbone slave-side bus bundle for wb_sram_responder.
// The master raises cyc/stb with we/sel/adr/dat; the slave answers with a one-cycle ack and registered read data.
interface wb_sram_responder_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone slave bridging single-word transfers onto a synchronous SRAM macro port.
// Every output is a flop; the FSM state is visible on o_dbg_state.
module wb_sram_responder #(
    parameter int ADDR_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_sram_responder_if.slave  wbs,
    output logic                sram_csb0,
    output logic                sram_web0,
    output logic [3:0]          sram_wmask0,
    output logic [ADDR_W-1:0]   sram_addr0,
    output logic [31:0]         sram_din0,
    input  logic [31:0]         sram_dout0,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_cnt;
    logic        w_req;
    logic        w_accept;
    logic        w_capture;
    logic        w_unused;

    assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_accept  = (r_state == IDLE) && (w_next == ACCESS);
    assign w_capture = (r_state == WAIT) && (w_next == ACK);
    assign o_dbg_state = r_state;
    // Byte offset and bits above the window belong to the address mux.
    assign w_unused  = &{1'b0, wbs.wbs_adr_i[31:ADDR_W+2], wbs.wbs_adr_i[1:0]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = ACCESS;
            ACCESS:  w_next = r_we ? ACK : WAIT;
            WAIT: begin
                if (!wbs.wbs_cyc_i)          w_next = IDLE;
                else if (r_cnt == LAST_WAIT) w_next = ACK;
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_cnt         <= '0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
            sram_csb0     <= 1'b1;
            sram_web0     <= 1'b1;
            sram_wmask0   <= 4'b0000;
            sram_addr0    <= '0;
            sram_din0     <= '0;
        end else begin
            r_state       <= w_next;
            wbs.wbs_ack_o <= (w_next == ACK);
            r_cnt         <= (r_state == WAIT) ? r_cnt + 3'd1 : 3'd0;
            // ACCESS is only ever entered from IDLE, so the live bus inputs are the request.
            sram_csb0     <= ~w_accept;
            sram_web0     <= w_accept ? ~wbs.wbs_we_i : 1'b1;
            sram_wmask0   <= (w_accept && wbs.wbs_we_i) ? wbs.wbs_sel_i : 4'b0000;
            if (w_accept) begin
                r_we       <= wbs.wbs_we_i;
                sram_addr0 <= wbs.wbs_adr_i[ADDR_W+1:2];
                sram_din0  <= wbs.wbs_dat_i;
            end
            if (w_capture) wbs.wbs_dat_o <= sram_dout0;
        end
    end

endmodule
